// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master pipelined Wishbone arbiter.
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int CNT_W = 16;
  localparam int ADR_W = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Pipelined Wishbone bus bundle (cyc/stb/stall handshake) with master and slave views.
interface wshb_if #(
  parameter int DATA_BYTES = 2
);
  // A transfer is consumed on a clock edge where cyc & stb & !stall; each
  // consumed transfer is answered later by exactly one ack (or err/rty) while cyc stays high.
  logic                            cyc;
  logic                            stb;
  logic                            we;
  logic [wshb_arb_pkg::ADR_W-1:0]  adr;
  logic [DATA_BYTES-1:0]           sel;
  logic [8*DATA_BYTES-1:0]         dat_ms;
  logic [8*DATA_BYTES-1:0]         dat_sm;
  logic [2:0]                      cti;
  logic [1:0]                      bte;
  logic                            ack;
  logic                            err;
  logic                            rty;
  logic                            stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_ms, cti, bte,
    input  dat_sm, ack, err, rty, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
    output dat_sm, ack, err, rty, stall
  );
endinterface

// File: rtl/wshb_arbiter.sv
// Two-master round-robin Wishbone arbiter granting whole bus cycles to one master at a time.
// Optional per-master ack counters are built when WSHB_ARB_STATS_EN is defined.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int DATA_BYTES = 2,
  parameter int FIRST_GNT  = 0
) (
  input  logic       CLK,
  input  logic       NRST,
  wshb_if.slave      wshb_ifs0,
  wshb_if.slave      wshb_ifs1,
  wshb_if.master     wshb_ifm,
  output logic [1:0] gnt,
  output arb_state_t state
`ifdef WSHB_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] ack_cnt0,
  output logic [CNT_W-1:0] ack_cnt1,
  input  logic             clear
`endif
);

  // last names the master served most recently; the other one wins a tie.
  localparam logic FIRST_LAST = (FIRST_GNT == 0);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic [8*DATA_BYTES-1:0] rd_data;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= IDLE;
      last_q  <= FIRST_LAST;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (wshb_ifs0.cyc && wshb_ifs1.cyc) state_d = last_q ? GNT0 : GNT1;
        else if (wshb_ifs0.cyc)             state_d = GNT0;
        else if (wshb_ifs1.cyc)             state_d = GNT1;
      end
      GNT0: begin
        if (!wshb_ifs0.cyc) begin
          last_d  = 1'b0;
          state_d = wshb_ifs1.cyc ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!wshb_ifs1.cyc) begin
          last_d  = 1'b1;
          state_d = wshb_ifs0.cyc ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The losing master sees stall=1, so its strobe is never consumed.
  always_comb begin
    wshb_ifm.cyc    = 1'b0;
    wshb_ifm.stb    = 1'b0;
    wshb_ifm.we     = 1'b0;
    wshb_ifm.adr    = '0;
    wshb_ifm.sel    = '0;
    wshb_ifm.dat_ms = '0;
    wshb_ifm.cti    = '0;
    wshb_ifm.bte    = '0;
    wshb_ifs0.ack   = 1'b0;
    wshb_ifs0.err   = 1'b0;
    wshb_ifs0.rty   = 1'b0;
    wshb_ifs0.stall = 1'b1;
    wshb_ifs1.ack   = 1'b0;
    wshb_ifs1.err   = 1'b0;
    wshb_ifs1.rty   = 1'b0;
    wshb_ifs1.stall = 1'b1;
    unique case (state_q)
      GNT0: begin
        wshb_ifm.cyc    = wshb_ifs0.cyc;
        wshb_ifm.stb    = wshb_ifs0.stb;
        wshb_ifm.we     = wshb_ifs0.we;
        wshb_ifm.adr    = wshb_ifs0.adr;
        wshb_ifm.sel    = wshb_ifs0.sel;
        wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
        wshb_ifm.cti    = wshb_ifs0.cti;
        wshb_ifm.bte    = wshb_ifs0.bte;
        wshb_ifs0.ack   = wshb_ifm.ack;
        wshb_ifs0.err   = wshb_ifm.err;
        wshb_ifs0.rty   = wshb_ifm.rty;
        wshb_ifs0.stall = wshb_ifm.stall;
      end
      GNT1: begin
        wshb_ifm.cyc    = wshb_ifs1.cyc;
        wshb_ifm.stb    = wshb_ifs1.stb;
        wshb_ifm.we     = wshb_ifs1.we;
        wshb_ifm.adr    = wshb_ifs1.adr;
        wshb_ifm.sel    = wshb_ifs1.sel;
        wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
        wshb_ifm.cti    = wshb_ifs1.cti;
        wshb_ifm.bte    = wshb_ifs1.bte;
        wshb_ifs1.ack   = wshb_ifm.ack;
        wshb_ifs1.err   = wshb_ifm.err;
        wshb_ifs1.rty   = wshb_ifm.rty;
        wshb_ifs1.stall = wshb_ifm.stall;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the granted master gets the ack that qualifies it.
  assign rd_data          = wshb_ifm.dat_sm;
  assign wshb_ifs0.dat_sm = rd_data;
  assign wshb_ifs1.dat_sm = rd_data;

  assign gnt   = {state_q == GNT1, state_q == GNT0};
  assign state = state_q;

`ifdef WSHB_ARB_STATS_EN
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      ack_cnt0 <= '0;
      ack_cnt1 <= '0;
    end else if (clear) begin
      ack_cnt0 <= '0;
      ack_cnt1 <= '0;
    end else begin
      if (wshb_ifs0.ack) ack_cnt0 <= sat_inc(ack_cnt0);
      if (wshb_ifs1.ack) ack_cnt1 <= sat_inc(ack_cnt1);
    end
  end
`endif

endmodule

// File: tb/tb_wshb_arbiter.sv
// Self-checking bench for wshb_arbiter: two job-driven masters, a random-stall memory slave,
// a rule-level grant model and a reference memory scoreboard.
module tb_wshb_arbiter;
  import wshb_arb_pkg::*;

  typedef struct {
    int          n;
    logic        we;
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    int          gap;
  } job_t;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  wshb_if #(.DATA_BYTES(2)) bus0 ();
  wshb_if #(.DATA_BYTES(2)) bus1 ();
  wshb_if #(.DATA_BYTES(2)) busm ();
  logic [1:0] gnt;
  arb_state_t state;
`ifdef WSHB_ARB_STATS_EN
  logic [15:0] ack_cnt0, ack_cnt1;
  logic        clear = 1'b0;
`endif

  wshb_arbiter #(.DATA_BYTES(2), .FIRST_GNT(0)) dut (
    .CLK(clk), .NRST(nrst),
    .wshb_ifs0(bus0), .wshb_ifs1(bus1), .wshb_ifm(busm),
    .gnt(gnt), .state(state)
`ifdef WSHB_ARB_STATS_EN
    , .ack_cnt0(ack_cnt0), .ack_cnt1(ack_cnt1), .clear(clear)
`endif
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  job_t jq0[$], jq1[$];
  job_t cur[2];
  job_t idle_job;
  int   busy[2], to_issue[2], issued[2], outstanding[2], gap[2];
  logic acc[2], ackd[2];
  int   acks_total[2];
  logic [15:0] last_rd[2];

  logic [16:0] exp_q0[$], exp_q1[$];
  logic [15:0] rmem[512];
  logic [15:0] smem[512];

  int exp_owner = -1;
  int exp_last  = 1;
  int glog[$];
  logic [1:0] prev_gnt = 2'b00;

  logic        s_acc = 1'b0, s_we = 1'b0;
  logic [31:0] s_adr = '0;
  logic [15:0] s_dat = '0;
  logic [1:0]  s_sel = '0;
  logic [1:0]  last_wsel = '0;
  logic        last_wwe  = 1'b0;

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [1:0] owner_gnt(input int o);
    return (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int m, input logic c, input logic s, input job_t j, input int k);
    logic [31:0] a;
    logic [15:0] d;
    a = j.adr + 32'(k);
    d = j.dat + 16'(k);
    if (m == 0) begin
      bus0.cyc = c; bus0.stb = s; bus0.we = j.we; bus0.adr = a;
      bus0.dat_ms = d; bus0.sel = j.sel; bus0.cti = '0; bus0.bte = '0;
    end else begin
      bus1.cyc = c; bus1.stb = s; bus1.we = j.we; bus1.adr = a;
      bus1.dat_ms = d; bus1.sel = j.sel; bus1.cti = '0; bus1.bte = '0;
    end
  endtask

  task automatic bench_reset_state();
    jq0.delete(); jq1.delete(); exp_q0.delete(); exp_q1.delete();
    for (int m = 0; m < 2; m++) begin
      busy[m] = 0; to_issue[m] = 0; issued[m] = 0; outstanding[m] = 0; gap[m] = 0;
      acc[m] = 1'b0; ackd[m] = 1'b0;
      drive(m, 1'b0, 1'b0, idle_job, 0);
    end
    busm.ack = 1'b0; busm.stall = 1'b1; s_acc = 1'b0;
  endtask

  // Negedge: compare against the grant model and the memory scoreboard.
  task automatic observe();
    logic c[2], sb[2], stl[2], ak[2], w[2];
    logic [31:0] a[2];
    logic [15:0] d[2], rd[2];
    logic [1:0]  sl[2];
    logic [16:0] e;
    int idx;
    c[0] = bus0.cyc; sb[0] = bus0.stb; stl[0] = bus0.stall; ak[0] = bus0.ack; w[0] = bus0.we;
    a[0] = bus0.adr; d[0] = bus0.dat_ms; sl[0] = bus0.sel; rd[0] = bus0.dat_sm;
    c[1] = bus1.cyc; sb[1] = bus1.stb; stl[1] = bus1.stall; ak[1] = bus1.ack; w[1] = bus1.we;
    a[1] = bus1.adr; d[1] = bus1.dat_ms; sl[1] = bus1.sel; rd[1] = bus1.dat_sm;
    acc[0] = 1'b0; acc[1] = 1'b0; ackd[0] = 1'b0; ackd[1] = 1'b0;

    if (!nrst) begin
      exp_owner = -1;
      exp_last  = 1;
    end
    check("gnt", {30'd0, gnt}, {30'd0, owner_gnt(exp_owner)});
    for (int m = 0; m < 2; m++) begin
      if (exp_owner != m) begin
        check("loser_stall", {31'd0, stl[m]}, 32'd1);
        check("loser_ack", {31'd0, ak[m]}, 32'd0);
      end
    end
    if (exp_owner < 0) check("idle_slave_cyc", {31'd0, busm.cyc}, 32'd0);
    if (gnt != 2'b00 && gnt != prev_gnt) glog.push_back((gnt == 2'b10) ? 1 : 0);
    prev_gnt = gnt;
    if (!nrst) return;

    for (int m = 0; m < 2; m++) begin
      acc[m]  = c[m] & sb[m] & ~stl[m];
      ackd[m] = ak[m];
      if (acc[m]) begin
        idx = int'(a[m][8:0]);
        if (w[m]) begin
          for (int b = 0; b < 2; b++) if (sl[m][b]) rmem[idx][8*b +: 8] = d[m][8*b +: 8];
          e = {1'b0, 16'h0};
        end else begin
          e = {1'b1, rmem[idx]};
        end
        if (m == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      end
      if (ak[m]) begin
        check("ack_has_request", {31'd0, (m == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0)}, 32'd1);
        if ((m == 0 && exp_q0.size() != 0) || (m == 1 && exp_q1.size() != 0)) begin
          e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          if (e[16]) begin
            check((m == 0) ? "rd_data_m0" : "rd_data_m1", {16'd0, rd[m]}, {16'd0, e[15:0]});
            last_rd[m] = rd[m];
          end
        end
        acks_total[m]++;
      end
    end

    s_acc = busm.cyc & busm.stb & ~busm.stall;
    s_adr = busm.adr; s_we = busm.we; s_dat = busm.dat_ms; s_sel = busm.sel;

    // Grant rules: hold while owner's cyc is high; on release hand over or go idle; tie -> not last.
    if (exp_owner >= 0) begin
      if (!c[exp_owner]) begin
        exp_last  = exp_owner;
        exp_owner = c[1 - exp_owner] ? 1 - exp_owner : -1;
      end
    end else if (c[0] && c[1]) exp_owner = 1 - exp_last;
    else if (c[0]) exp_owner = 0;
    else if (c[1]) exp_owner = 1;
  endtask

  // Posedge+1: memory slave with random stall, ack one cycle after acceptance.
  task automatic step_slave();
    int idx;
    if (!nrst) begin
      busm.ack = 1'b0; busm.stall = 1'b1;
      return;
    end
    busm.ack = s_acc;
    if (s_acc) begin
      idx = int'(s_adr[8:0]);
      if (s_we) begin
        for (int b = 0; b < 2; b++) if (s_sel[b]) smem[idx][8*b +: 8] = s_dat[8*b +: 8];
        last_wsel = s_sel; last_wwe = s_we;
      end else begin
        busm.dat_sm = smem[idx];
      end
    end
    busm.stall = ($urandom_range(0, 3) == 0);
  endtask

  task automatic step_masters();
    for (int m = 0; m < 2; m++) begin
      if (busy[m] != 0) begin
        if (acc[m]) begin to_issue[m]--; issued[m]++; outstanding[m]++; end
        if (ackd[m]) outstanding[m]--;
        if (to_issue[m] == 0 && outstanding[m] == 0) begin
          busy[m] = 0; gap[m] = cur[m].gap;
          drive(m, 1'b0, 1'b0, idle_job, 0);
        end else begin
          drive(m, 1'b1, (to_issue[m] > 0), cur[m], issued[m]);
        end
      end else if (gap[m] > 0) begin
        gap[m]--;
      end else if ((m == 0 && jq0.size() != 0) || (m == 1 && jq1.size() != 0)) begin
        cur[m] = (m == 0) ? jq0.pop_front() : jq1.pop_front();
        busy[m] = 1; to_issue[m] = cur[m].n; issued[m] = 0; outstanding[m] = 0;
        drive(m, 1'b1, 1'b1, cur[m], 0);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    step_slave();
    step_masters();
  endtask

  task automatic pulse_reset();
    nrst = 1'b0;
    bench_reset_state();
    cycle();
    cycle();
    nrst = 1'b1;
  endtask

  task automatic run_until_done(input int budget);
    int k = 0;
    while ((jq0.size() != 0 || jq1.size() != 0 || busy[0] != 0 || busy[1] != 0) && k < budget) begin
      cycle();
      k++;
    end
    check("run_within_budget", {31'd0, k < budget}, 32'd1);
    cycle();
    cycle();
  endtask

  function automatic job_t mk(input int n, input logic we, input logic [31:0] adr,
                              input logic [15:0] dat, input logic [1:0] sel, input int g);
    job_t j;
    j.n = n; j.we = we; j.adr = adr; j.dat = dat; j.sel = sel; j.gap = g;
    return j;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] v;
    int base;
    idle_job = mk(0, 1'b0, 32'd0, 16'd0, 2'b00, 0);
    for (int i = 0; i < 512; i++) begin
      v = 16'($urandom);
      smem[i] = v; rmem[i] = v;
    end
    busm.err = 1'b0; busm.rty = 1'b0; busm.dat_sm = '0;
    acks_total[0] = 0; acks_total[1] = 0;
    last_rd[0] = '0; last_rd[1] = '0;
    bench_reset_state();
    #1;
    cycle();
    cycle();
    nrst = 1'b1;

    // Only master 0 requests: eight reads, master 1 never granted.
    glog.delete();
    jq0.push_back(mk(8, 1'b0, 32'h10, 16'h0, 2'b11, 0));
    run_until_done(500);
    check("t1_acks_m0", 32'(acks_total[0]), 32'd8);
    check("t1_acks_m1", 32'(acks_total[1]), 32'd0);
    check("t1_grants", 32'(glog.size()), 32'd1);
    if (glog.size() != 0) check("t1_first_owner", 32'(glog[0]), 32'd0);

    // Both request from reset: master 0 first, then master 1 with no idle gap.
    pulse_reset();
    glog.delete();
    jq0.push_back(mk(4, 1'b0, 32'h20, 16'h0, 2'b11, 0));
    jq1.push_back(mk(4, 1'b0, 32'h40, 16'h0, 2'b11, 0));
    run_until_done(500);
    check("t2_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("t2_first", 32'(glog[0]), 32'd0);
      check("t2_second", 32'(glog[1]), 32'd1);
    end

    // Continuous requests, four acks per burst: strict alternation.
    glog.delete();
    for (int i = 0; i < 3; i++) begin
      jq0.push_back(mk(4, 1'b0, 32'(64 + 8 * i), 16'h0, 2'b11, 0));
      jq1.push_back(mk(4, 1'b0, 32'(128 + 8 * i), 16'h0, 2'b11, 0));
    end
    run_until_done(1000);
    check("t3_grants", 32'(glog.size()), 32'd6);
    for (int i = 0; i < glog.size() && i < 6; i++) check("t3_alternate", 32'(glog[i]), 32'(i % 2));

    // Reset in the middle of a master 1 burst after three acks.
    pulse_reset();
    base = acks_total[1];
    jq1.push_back(mk(8, 1'b0, 32'h80, 16'h0, 2'b11, 0));
    for (int k = 0; k < 200 && acks_total[1] - base < 3; k++) cycle();
    check("t4_three_acks", 32'(acks_total[1] - base), 32'd3);
    #2;
    nrst = 1'b0;
    #1;
    check("t4_gnt", {30'd0, gnt}, 32'd0);
    check("t4_slave_cyc", {31'd0, busm.cyc}, 32'd0);
    check("t4_m1_ack", {31'd0, bus1.ack}, 32'd0);
    check("t4_m1_stall", {31'd0, bus1.stall}, 32'd1);
    bench_reset_state();
    cycle();
    nrst = 1'b1;
    cycle();

    // Master 1 writes, master 0 reads back through the shared slave.
    jq1.push_back(mk(1, 1'b1, 32'h100, 16'hA5A5, 2'b11, 0));
    run_until_done(300);
    check("t5_slave_we", {31'd0, last_wwe}, 32'd1);
    check("t5_slave_sel", {30'd0, last_wsel}, 32'd3);
    check("t5_slave_mem", {16'd0, smem[256]}, 32'hA5A5);
    jq0.push_back(mk(1, 1'b0, 32'h100, 16'h0, 2'b11, 0));
    run_until_done(300);
    check("t5_m0_readback", {16'd0, last_rd[0]}, 32'hA5A5);

    // Randomized traffic from both masters.
    for (int i = 0; i < 30; i++) begin
      jq0.push_back(mk($urandom_range(1, 8), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 500)),
                       16'($urandom), 2'($urandom_range(1, 3)), $urandom_range(0, 3)));
      jq1.push_back(mk($urandom_range(1, 8), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 500)),
                       16'($urandom), 2'($urandom_range(1, 3)), $urandom_range(0, 3)));
    end
    run_until_done(20000);
    check("rand_m0_drained", 32'(exp_q0.size()), 32'd0);
    check("rand_m1_drained", 32'(exp_q1.size()), 32'd0);

`ifdef WSHB_ARB_STATS_EN
    pulse_reset();
    check("t6_cnt0_reset", {16'd0, ack_cnt0}, 32'd0);
    jq0.push_back(mk(10, 1'b0, 32'h0, 16'h0, 2'b11, 0));
    jq1.push_back(mk(3, 1'b0, 32'h30, 16'h0, 2'b11, 0));
    run_until_done(1000);
    check("t6_cnt0", {16'd0, ack_cnt0}, 32'd10);
    check("t6_cnt1", {16'd0, ack_cnt1}, 32'd3);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("t6_clr0", {16'd0, ack_cnt0}, 32'd0);
    check("t6_clr1", {16'd0, ack_cnt1}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
